// File: rtl/mem_port_arbiter_if.sv
// Purpose: bundle of the fetch, data/AMO and line-RAM signals around mem_port_arbiter.
// Signal suffixes (_i/_o) are named from the arbiter's point of view.
//   ins_*  : instruction-fetch request/grant/response
//   dat_*  : data/AMO request (we, lock, wdata, wmask)/grant/response
//   mem_*  : single-port 128-bit line RAM strobe/command/ack/read data
//   lock_* : lock status and forced-release pulse
// Modports: slave = arbiter side, master = environment (core + RAM) side.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              ins_req_i;
    logic [31:0]       ins_addr_i;
    logic              ins_gnt_o;
    logic              ins_rvalid_o;
    logic [127:0]      ins_rdata_o;

    logic              dat_req_i;
    logic              dat_we_i;
    logic              dat_lock_i;
    logic [31:0]       dat_addr_i;
    logic [127:0]      dat_wdata_i;
    logic [15:0]       dat_wmask_i;
    logic              dat_gnt_o;
    logic              dat_rvalid_o;
    logic [127:0]      dat_rdata_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [127:0]      mem_wdata_o;
    logic [15:0]       mem_wmask_o;
    logic              mem_ack_i;
    logic [127:0]      mem_rdata_i;

    logic              lock_active_o;
    logic              lock_timeout_o;

    modport slave (
        input  ins_req_i, ins_addr_i,
        output ins_gnt_o, ins_rvalid_o, ins_rdata_o,
        input  dat_req_i, dat_we_i, dat_lock_i, dat_addr_i, dat_wdata_i, dat_wmask_i,
        output dat_gnt_o, dat_rvalid_o, dat_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
        input  mem_ack_i, mem_rdata_i,
        output lock_active_o, lock_timeout_o
    );

    modport master (
        output ins_req_i, ins_addr_i,
        input  ins_gnt_o, ins_rvalid_o, ins_rdata_o,
        output dat_req_i, dat_we_i, dat_lock_i, dat_addr_i, dat_wdata_i, dat_wmask_i,
        input  dat_gnt_o, dat_rvalid_o, dat_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
        output mem_ack_i, mem_rdata_i,
        input  lock_active_o, lock_timeout_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: arbitrates the instruction-fetch and data/AMO ports onto one line RAM,
// one transaction outstanding, data-favoured with bounded fetch starvation, and a
// bus lock that keeps AMO / LR-SC accesses back-to-back.
// Ports:
//   CLK  : clock, rising edge
//   RST  : synchronous active-high reset
//   bus  : mem_port_arbiter_if.slave (fetch port, data port, RAM port, lock status)
// Grants (ins_gnt_o/dat_gnt_o) are combinational; every other output is a flop.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned LOCK_TIMEOUT = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    mem_port_arbiter_if.slave    bus
);
    localparam int unsigned LINE_W   = 128;
    localparam int unsigned MASK_W   = 16;
    localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam int unsigned TMO_W    = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_LOCKED = 2'd3
    } state_e;

    typedef enum logic {
        OWN_INS = 1'b0,
        OWN_DAT = 1'b1
    } owner_e;

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic                lock_q, lock_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                mem_req_q, mem_req_d;
    logic                ins_rvalid_q, ins_rvalid_d;
    logic [LINE_W-1:0]   ins_rdata_q, ins_rdata_d;
    logic                dat_rvalid_q, dat_rvalid_d;
    logic [LINE_W-1:0]   dat_rdata_q, dat_rdata_d;
    logic                lock_active_q, lock_active_d;
    logic                lock_timeout_q, lock_timeout_d;
    logic                ins_gnt_c, dat_gnt_c;

    // Byte-offset and upper address bits never reach the RAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.ins_addr_i[31:ADDR_W+4], bus.ins_addr_i[3:0],
                                bus.dat_addr_i[31:ADDR_W+4], bus.dat_addr_i[3:0]};

    // Next-state, arbitration and command capture.
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        wmask_d        = wmask_q;
        lock_d         = lock_q;
        streak_d       = streak_q;
        tmo_d          = tmo_q;
        ins_rvalid_d   = 1'b0;
        ins_rdata_d    = '0;
        dat_rvalid_d   = 1'b0;
        dat_rdata_d    = '0;
        lock_timeout_d = 1'b0;
        ins_gnt_c      = 1'b0;
        dat_gnt_c      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Data wins unless the fetch port has waited out a full streak.
                if (bus.dat_req_i &&
                    !(bus.ins_req_i && streak_q == STREAK_W'(MAX_D_STREAK))) begin
                    dat_gnt_c = 1'b1;
                end else if (bus.ins_req_i) begin
                    ins_gnt_c = 1'b1;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.mem_ack_i) begin
                    if (owner_q == OWN_DAT) begin
                        dat_rvalid_d = 1'b1;
                        dat_rdata_d  = we_q ? '0 : bus.mem_rdata_i;
                    end else begin
                        ins_rvalid_d = 1'b1;
                        ins_rdata_d  = bus.mem_rdata_i;
                    end
                    if (lock_q) begin
                        state_d = S_LOCKED;
                        tmo_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_LOCKED: begin
                // Forced release takes priority over a data request in the same cycle.
                if (tmo_q == TMO_W'(LOCK_TIMEOUT)) begin
                    state_d = S_IDLE;
                    tmo_d   = '0;
                end else if (bus.dat_req_i) begin
                    dat_gnt_c = 1'b1;
                end else begin
                    tmo_d          = tmo_q + TMO_W'(1);
                    lock_timeout_d = (tmo_q == TMO_W'(LOCK_TIMEOUT - 1));
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (dat_gnt_c) begin
            state_d  = S_ISSUE;
            owner_d  = OWN_DAT;
            we_d     = bus.dat_we_i;
            addr_d   = bus.dat_addr_i[ADDR_W+3:4];
            wdata_d  = bus.dat_wdata_i;
            wmask_d  = bus.dat_wmask_i;
            lock_d   = bus.dat_lock_i;
            tmo_d    = '0;
            if (!bus.ins_req_i) begin
                streak_d = '0;
            end else if (streak_q != STREAK_W'(MAX_D_STREAK)) begin
                streak_d = streak_q + STREAK_W'(1);
            end
        end

        if (ins_gnt_c) begin
            state_d  = S_ISSUE;
            owner_d  = OWN_INS;
            we_d     = 1'b0;
            addr_d   = bus.ins_addr_i[ADDR_W+3:4];
            wdata_d  = '0;
            wmask_d  = '0;
            lock_d   = 1'b0;
            streak_d = '0;
        end

        // Strobe and lock flag are decoded from the next state so they leave a flop.
        mem_req_d     = (state_d == S_ISSUE);
        lock_active_d = (state_d == S_LOCKED);
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= S_IDLE;
            owner_q        <= OWN_INS;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            wmask_q        <= '0;
            lock_q         <= 1'b0;
            streak_q       <= '0;
            tmo_q          <= '0;
            mem_req_q      <= 1'b0;
            ins_rvalid_q   <= 1'b0;
            ins_rdata_q    <= '0;
            dat_rvalid_q   <= 1'b0;
            dat_rdata_q    <= '0;
            lock_active_q  <= 1'b0;
            lock_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            wmask_q        <= wmask_d;
            lock_q         <= lock_d;
            streak_q       <= streak_d;
            tmo_q          <= tmo_d;
            mem_req_q      <= mem_req_d;
            ins_rvalid_q   <= ins_rvalid_d;
            ins_rdata_q    <= ins_rdata_d;
            dat_rvalid_q   <= dat_rvalid_d;
            dat_rdata_q    <= dat_rdata_d;
            lock_active_q  <= lock_active_d;
            lock_timeout_q <= lock_timeout_d;
        end
    end

    assign bus.ins_gnt_o      = ins_gnt_c;
    assign bus.dat_gnt_o      = dat_gnt_c;
    assign bus.ins_rvalid_o   = ins_rvalid_q;
    assign bus.ins_rdata_o    = ins_rdata_q;
    assign bus.dat_rvalid_o   = dat_rvalid_q;
    assign bus.dat_rdata_o    = dat_rdata_q;
    assign bus.mem_req_o      = mem_req_q;
    assign bus.mem_we_o       = we_q;
    assign bus.mem_addr_o     = addr_q;
    assign bus.mem_wdata_o    = wdata_q;
    assign bus.mem_wmask_o    = wmask_q;
    assign bus.lock_active_o  = lock_active_q;
    assign bus.lock_timeout_o = lock_timeout_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: behavioural line RAM with a one-cycle ack,
// plus a manual ack path used to inject a late ack across reset.
module tb_mem_port_arbiter;
    logic CLK;
    logic RST;

    mem_port_arbiter_if #(.ADDR_W(8)) bus ();

    mem_port_arbiter #(
        .ADDR_W(8),
        .MAX_D_STREAK(4),
        .LOCK_TIMEOUT(16)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_err    = 0;

    // RAM model
    logic [127:0] ram [256];
    logic         auto_ack;
    logic         ram_ack;
    logic [127:0] ram_rdata;
    logic         man_ack;
    logic [127:0] man_rdata;
    logic         pl_we;
    logic [7:0]   pl_addr;
    logic [127:0] pl_data;

    assign bus.mem_ack_i   = ram_ack | man_ack;
    assign bus.mem_rdata_i = ram_ack ? ram_rdata : man_rdata;

    always @(posedge CLK) begin
        ram_ack <= 1'b0;
        if (pl_we) ram[pl_addr] <= pl_data;
        if (auto_ack && bus.mem_req_o) begin
            ram_ack   <= 1'b1;
            ram_rdata <= ram[bus.mem_addr_o];
            if (bus.mem_we_o) begin
                for (int b = 0; b < 16; b++) begin
                    if (bus.mem_wmask_o[b])
                        ram[bus.mem_addr_o][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [127:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_we = 1'b0;
    endtask

    task automatic set_dat(input logic req, input logic we, input logic lock,
                           input logic [31:0] addr, input logic [127:0] wd,
                           input logic [15:0] wm);
        bus.dat_req_i   = req;
        bus.dat_we_i    = we;
        bus.dat_lock_i  = lock;
        bus.dat_addr_i  = addr;
        bus.dat_wdata_i = wd;
        bus.dat_wmask_i = wm;
    endtask

    localparam logic [127:0] FETCH_LINE = 128'h0000006f_0021a11f;

    initial begin
        int ng;
        int pulses;
        int pulse_cycle;
        logic [9:0] exp_order;

        RST = 1'b1;
        auto_ack = 1'b1; ram_ack = 1'b0; ram_rdata = '0;
        man_ack = 1'b0; man_rdata = '0;
        pl_we = 1'b0; pl_addr = '0; pl_data = '0;
        bus.ins_req_i = 1'b0; bus.ins_addr_i = '0;
        set_dat(1'b0, 1'b0, 1'b0, 32'h0, '0, '0);

        // Reset state
        tick(); tick();
        chk("rst_ins_gnt", bus.ins_gnt_o, 0);
        chk("rst_dat_gnt", bus.dat_gnt_o, 0);
        chk("rst_mem_req", bus.mem_req_o, 0);
        chk("rst_mem_addr", bus.mem_addr_o, 0);
        chk("rst_lock_active", bus.lock_active_o, 0);
        chk("rst_rvalid", {bus.ins_rvalid_o, bus.dat_rvalid_o}, 0);
        RST = 1'b0;

        preload(8'd1, FETCH_LINE);
        preload(8'd0, 128'd30);
        preload(8'd4, 128'h0123456789abcdef_fedcba9876543210);

        // Fetch only
        bus.ins_req_i = 1'b1; bus.ins_addr_i = 32'h10;
        #1;
        chk("fetch_gnt", bus.ins_gnt_o, 1);
        chk("fetch_no_dgnt", bus.dat_gnt_o, 0);
        tick(); bus.ins_req_i = 1'b0;
        chk("fetch_mem_req", bus.mem_req_o, 1);
        chk("fetch_mem_addr", bus.mem_addr_o, 1);
        chk("fetch_mem_we", bus.mem_we_o, 0);
        tick();
        chk("fetch_req_1cyc", bus.mem_req_o, 0);
        chk("fetch_rvalid_c2", bus.ins_rvalid_o, 0);
        tick();
        chk("fetch_rvalid_c3", bus.ins_rvalid_o, 1);
        chk("fetch_rdata", bus.ins_rdata_o, FETCH_LINE);
        tick();
        chk("fetch_rvalid_pulse", bus.ins_rvalid_o, 0);

        // Contention: expected D D D D I D D D D I (index 0 first, 1 = data)
        exp_order = 10'b0111101111;
        bus.ins_req_i = 1'b1; bus.ins_addr_i = 32'h20;
        set_dat(1'b1, 1'b0, 1'b0, 32'h30, '0, '0);
        ng = 0;
        for (int c = 0; c < 60 && ng < 10; c++) begin
            #1;
            if (bus.dat_gnt_o || bus.ins_gnt_o) begin
                chk("contention_order", {bus.dat_gnt_o, bus.ins_gnt_o},
                    {exp_order[ng], ~exp_order[ng]});
                ng++;
            end
            tick();
            if (ng == 10) begin
                bus.ins_req_i = 1'b0; bus.dat_req_i = 1'b0;
            end
        end
        bus.ins_req_i = 1'b0; bus.dat_req_i = 1'b0;
        chk("contention_grants", ng, 10);
        repeat (4) tick();

        // AMO pair with fetch pending throughout
        bus.ins_req_i = 1'b1; bus.ins_addr_i = 32'h10;
        set_dat(1'b1, 1'b0, 1'b1, 32'h8000_1000, '0, '0);
        #1;
        chk("amo_rd_gnt", {bus.dat_gnt_o, bus.ins_gnt_o}, 2'b10);
        tick(); bus.dat_req_i = 1'b0;
        chk("amo_rd_addr", bus.mem_addr_o, 0);
        tick();
        chk("amo_wait_no_igrant", bus.ins_gnt_o, 0);
        tick();
        chk("amo_rd_rvalid", bus.dat_rvalid_o, 1);
        chk("amo_rd_data", bus.dat_rdata_o, 128'd30);
        chk("amo_locked", bus.lock_active_o, 1);
        chk("amo_locked_no_igrant", bus.ins_gnt_o, 0);
        tick();
        chk("amo_locked2", bus.lock_active_o, 1);
        chk("amo_locked2_no_igrant", bus.ins_gnt_o, 0);
        set_dat(1'b1, 1'b1, 1'b0, 32'h8000_1000, 128'd90, 16'hFFFF);
        #1;
        chk("amo_wr_gnt", {bus.dat_gnt_o, bus.ins_gnt_o}, 2'b10);
        tick(); bus.dat_req_i = 1'b0;
        chk("amo_wr_req", {bus.mem_req_o, bus.mem_we_o}, 2'b11);
        chk("amo_wr_data", bus.mem_wdata_o, 128'd90);
        chk("amo_issue_no_igrant", bus.ins_gnt_o, 0);
        tick();
        chk("amo_wait2_no_igrant", bus.ins_gnt_o, 0);
        tick();
        chk("amo_wr_rvalid", bus.dat_rvalid_o, 1);
        chk("amo_wr_rdata_zero", bus.dat_rdata_o, 0);
        chk("amo_released", bus.lock_active_o, 0);
        chk("amo_igrant_after", bus.ins_gnt_o, 1);
        tick(); bus.ins_req_i = 1'b0;
        chk("amo_ram_line", ram[0], 128'd90);
        repeat (3) tick();

        // Lock timeout
        bus.ins_req_i = 1'b1; bus.ins_addr_i = 32'h10;
        set_dat(1'b1, 1'b0, 1'b1, 32'h20, '0, '0);
        #1;
        chk("tmo_gnt", bus.dat_gnt_o, 1);
        tick(); bus.dat_req_i = 1'b0;
        tick(); tick();
        pulses = 0; pulse_cycle = -1;
        for (int c = 3; c <= 19; c++) begin
            if (bus.lock_timeout_o) begin
                pulses++;
                pulse_cycle = c;
            end
            chk("tmo_no_igrant", bus.ins_gnt_o, 0);
            tick();
        end
        chk("tmo_pulses", pulses, 1);
        chk("tmo_pulse_cycle", pulse_cycle, 19);
        chk("tmo_pulse_done", bus.lock_timeout_o, 0);
        chk("tmo_unlocked", bus.lock_active_o, 0);
        chk("tmo_igrant", bus.ins_gnt_o, 1);
        tick(); bus.ins_req_i = 1'b0;
        repeat (3) tick();

        // Reset while waiting for the RAM; late ack afterwards
        auto_ack = 1'b0;
        set_dat(1'b1, 1'b0, 1'b0, 32'h30, '0, '0);
        #1;
        chk("rstw_gnt", bus.dat_gnt_o, 1);
        tick(); bus.dat_req_i = 1'b0;
        chk("rstw_mem_req", bus.mem_req_o, 1);
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("rstw_outputs", {bus.mem_req_o, bus.dat_rvalid_o, bus.ins_rvalid_o,
                             bus.lock_active_o, bus.lock_timeout_o}, 0);
        chk("rstw_addr", bus.mem_addr_o, 0);
        man_ack = 1'b1; man_rdata = 128'hDEAD;
        tick();
        man_ack = 1'b0;
        chk("rstw_no_rvalid", bus.dat_rvalid_o, 0);
        tick();
        chk("rstw_no_rvalid2", bus.dat_rvalid_o, 0);
        auto_ack = 1'b1;

        // Masked write (also shows the FSM is back in IDLE)
        set_dat(1'b1, 1'b1, 1'b0, 32'h40, {16{8'hAB}}, 16'h000F);
        #1;
        chk("mw_gnt", bus.dat_gnt_o, 1);
        tick(); bus.dat_req_i = 1'b0;
        chk("mw_we", {bus.mem_req_o, bus.mem_we_o}, 2'b11);
        chk("mw_mask", bus.mem_wmask_o, 16'h000F);
        chk("mw_addr", bus.mem_addr_o, 4);
        tick(); tick();
        chk("mw_rvalid", bus.dat_rvalid_o, 1);
        chk("mw_rdata_zero", bus.dat_rdata_o, 0);
        chk("mw_ram", ram[4], 128'h0123456789abcdef_fedcba98_abababab);

        // Zero-mask write is still issued and leaves the line intact
        set_dat(1'b1, 1'b1, 1'b0, 32'h40, 128'h55, 16'h0000);
        #1;
        chk("zm_gnt", bus.dat_gnt_o, 1);
        tick(); bus.dat_req_i = 1'b0;
        chk("zm_req", {bus.mem_req_o, bus.mem_we_o, bus.mem_wmask_o}, {2'b11, 16'h0000});
        tick(); tick();
        chk("zm_rvalid", bus.dat_rvalid_o, 1);
        chk("zm_ram", ram[4], 128'h0123456789abcdef_fedcba98_abababab);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
